// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one radix-2 shift-add or restoring-divide step per
// cycle on operand magnitudes, followed by a single sign-fix/accumulate cycle.
`timescale 1ns/1ps
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_hi,
    output logic [WIDTH-1:0] resp_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_reg;
    logic [CW-1:0]      count_reg;
    logic [1:0]         kind_reg;      // op[2:1]: 00 mul, 01 div, 10 madd, 11 msub
    logic [WIDTH-1:0]   a_mag_reg;
    logic [WIDTH-1:0]   b_mag_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   acc_hi_reg;
    logic [WIDTH-1:0]   acc_lo_reg;
    logic               a_neg_reg;
    logic               b_neg_reg;
    logic               dbz_reg;
    logic               resp_valid_reg;
    logic               dbz_out_reg;
    logic [WIDTH-1:0]   resp_hi_reg;
    logic [WIDTH-1:0]   resp_lo_reg;

    // Accept-time operand decode
    logic               in_signed;
    logic               in_div;
    logic               in_a_neg;
    logic               in_b_neg;
    logic               in_dbz;
    logic [WIDTH-1:0]   in_a_mag;
    logic [WIDTH-1:0]   in_b_mag;

    assign in_signed = ~op[0];
    assign in_div    = (op[2:1] == 2'b01);
    assign in_a_neg  = in_signed & src_a[WIDTH-1];
    assign in_b_neg  = in_signed & src_b[WIDTH-1];
    assign in_a_mag  = in_a_neg ? -src_a : src_a;
    assign in_b_mag  = in_b_neg ? -src_b : src_b;
    assign in_dbz    = in_div && (src_b == '0);

    assign req_ready = rst && (state_reg == IDLE);

    // Multiply step: add multiplicand when the current multiplier bit is set, shift right
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_next;
    logic [WIDTH-1:0]   mul_lo_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign mul_addend[gi] = a_mag_reg[gi] & lo_reg[0];
        end
    endgenerate

    assign mul_sum     = {1'b0, hi_reg} + {1'b0, mul_addend};
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

    // Restoring divide step: remainder in hi_reg, dividend shifting out of / quotient into lo_reg
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_hi_next;
    logic [WIDTH-1:0]   div_lo_next;

    assign div_shift   = {hi_reg, lo_reg[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, b_mag_reg};
    assign div_ok      = ~div_diff[WIDTH];
    assign div_hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {lo_reg[WIDTH-2:0], div_ok};

    // Sign correction and accumulate, evaluated during FIX
    logic                 res_neg;
    logic [2*WIDTH-1:0]   prod_mag;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    assign res_neg = a_neg_reg ^ b_neg_reg;

    always_comb begin
        prod_mag   = {hi_reg, lo_reg};
        prod_fixed = res_neg ? -prod_mag : prod_mag;
        acc        = {acc_hi_reg, acc_lo_reg};
        mul_res    = prod_fixed;
        if (kind_reg == 2'b10) begin
            mul_res = acc + prod_fixed;
        end else if (kind_reg == 2'b11) begin
            mul_res = acc - prod_fixed;
        end
        fix_hi = mul_res[2*WIDTH-1:WIDTH];
        fix_lo = mul_res[WIDTH-1:0];
        if (kind_reg == 2'b01) begin
            if (dbz_reg) begin
                fix_hi = hi_reg;
                fix_lo = '1;
            end else begin
                // Quotient truncates toward zero; remainder follows the dividend
                fix_lo = res_neg   ? -lo_reg : lo_reg;
                fix_hi = a_neg_reg ? -hi_reg : hi_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            kind_reg       <= '0;
            a_mag_reg      <= '0;
            b_mag_reg      <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            acc_hi_reg     <= '0;
            acc_lo_reg     <= '0;
            a_neg_reg      <= 1'b0;
            b_neg_reg      <= 1'b0;
            dbz_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
            dbz_out_reg    <= 1'b0;
            resp_hi_reg    <= '0;
            resp_lo_reg    <= '0;
        end else if (flush) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        kind_reg   <= op[2:1];
                        a_mag_reg  <= in_a_mag;
                        b_mag_reg  <= in_b_mag;
                        a_neg_reg  <= in_a_neg;
                        b_neg_reg  <= in_b_neg;
                        dbz_reg    <= in_dbz;
                        acc_hi_reg <= hi_in;
                        acc_lo_reg <= lo_in;
                        count_reg  <= '0;
                        // Divide-by-zero carries the raw dividend straight to FIX
                        hi_reg     <= in_dbz ? src_a : '0;
                        lo_reg     <= in_div ? in_a_mag : in_b_mag;
                        state_reg  <= in_dbz ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (kind_reg == 2'b01) begin
                        hi_reg <= div_hi_next;
                        lo_reg <= div_lo_next;
                    end else begin
                        hi_reg <= mul_hi_next;
                        lo_reg <= mul_lo_next;
                    end
                    if (count_reg == CW'(WIDTH-1)) begin
                        count_reg <= '0;
                        state_reg <= FIX;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                FIX: begin
                    resp_hi_reg    <= fix_hi;
                    resp_lo_reg    <= fix_lo;
                    dbz_out_reg    <= dbz_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign resp_valid  = resp_valid_reg;
    assign resp_hi     = resp_hi_reg;
    assign resp_lo     = resp_lo_reg;
    assign div_by_zero = dbz_out_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected results, a negedge monitor
// checks every cycle a result is presented, including latency and hold stability.
`timescale 1ns/1ps
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [W-1:0] hi_in = '0;
    logic [W-1:0] lo_in = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_hi;
    logic [W-1:0] resp_lo;
    logic         div_by_zero;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_in(hi_in), .lo_in(lo_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hi(resp_hi), .resp_lo(resp_lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    bit in_resp = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compare the presented result every cycle; pop on handshake or flush
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp got hi=%h lo=%h want no response", resp_hi, resp_lo);
            end else begin
                if (!in_resp) begin
                    check({q[0].name, "_lat"}, 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                    in_resp = 1'b1;
                end
                check({q[0].name, "_hi"}, 64'(resp_hi), 64'(q[0].hi));
                check({q[0].name, "_lo"}, 64'(resp_lo), 64'(q[0].lo));
                check({q[0].name, "_dbz"}, 64'(div_by_zero), 64'(q[0].dbz));
                $display("resp %s hi=%h lo=%h dbz=%0d", q[0].name, resp_hi, resp_lo, div_by_zero);
                if (resp_ready || flush) begin
                    void'(q.pop_front());
                    in_resp = 1'b0;
                end
            end
        end else begin
            in_resp = 1'b0;
        end
    end

    task automatic wait_ready(string name, output bit ok);
        int t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        ok = req_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_ready got timeout want req_ready=1", name);
        end
    endtask

    task automatic issue(string name, logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] hi, logic [W-1:0] lo,
                         logic [W-1:0] eh, logic [W-1:0] el, logic ed, int lat);
        bit ok;
        wait_ready(name, ok);
        if (!ok) return;
        op = o; src_a = a; src_b = b; hi_in = hi; lo_in = lo;
        req_valid = 1'b1;
        q.push_back('{eh, el, ed, cyc + 1, lat, name});
        $display("req  %s op=%0d a=%h b=%h hi=%h lo=%h", name, o, a, b, hi, lo);
        @(posedge clk); #1;
        // Scramble inputs after the accept edge: they must not matter any more
        req_valid = 1'b0;
        op = ~o; src_a = ~a; src_b = ~b; hi_in = ~hi; lo_in = ~lo;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || resp_valid) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain got timeout want result within budget");
            q.delete();
        end
    endtask

    task automatic run(string name, logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] hi, logic [W-1:0] lo,
                       logic [W-1:0] eh, logic [W-1:0] el, logic ed, int lat);
        issue(name, o, a, b, hi, lo, eh, el, ed, lat);
        drain();
    endtask

    task automatic wait_valid(string name);
        int t = 0;
        while (!resp_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_valid got timeout want resp_valid=1", name);
        end
    endtask

    initial begin
        bit ok;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_hi", 64'(resp_hi), 64'd0);
        check("rst_resp_lo", 64'(resp_lo), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        //        name        op    a             b             hi_in         lo_in         exp_hi        exp_lo        dbz  lat
        run("mult_m1x2",   3'd0, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, W+2);
        run("multu_m1x2",  3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFE, 1'b0, W+2);
        run("mult_m3x5",   3'd0, 32'hFFFFFFFD, 32'h00000005, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, W+2);
        run("mult_minsq",  3'd0, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000, 1'b0, W+2);
        run("divu_100_7",  3'd3, 32'd100,      32'd7,        32'h0,        32'h0,        32'd2,        32'd14,       1'b0, W+2);
        run("divu_big",    3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0,        32'h0,        32'h0000000F, 32'h0FFFFFFF, 1'b0, W+2);
        run("div_m7_2",    3'd2, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W+2);
        run("div_7_m2",    3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 1'b0, W+2);
        run("div_min_m1",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000, 1'b0, W+2);
        run("div_by0",     3'd2, 32'h12345678, 32'h00000000, 32'h0,        32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2);
        run("divu_by0",    3'd3, 32'h00000005, 32'h00000000, 32'h0,        32'h0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2);
        run("maddu_carry", 3'd5, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, W+2);
        run("msub_borrow", 3'd6, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, W+2);
        run("madd_neg",    3'd4, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h0000000A, 32'h00000000, 32'h00000004, 1'b0, W+2);
        run("msubu",       3'd7, 32'h00000002, 32'h00000003, 32'h00000001, 32'h00000000, 32'h00000000, 32'hFFFFFFFA, 1'b0, W+2);

        // Flush mid-CALC: nothing comes out, unit is ready next cycle
        wait_ready("flush_calc", ok);
        op = 3'd1; src_a = 32'd7; src_b = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc_valid", 64'(resp_valid), 64'd0);
        check("flush_calc_ready", 64'(req_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        run("multu_3x5",   3'd1, 32'd3,        32'd5,        32'h0,        32'h0,        32'd0,        32'd15,       1'b0, W+2);

        // Flush coinciding with accept: request dropped
        wait_ready("flush_acc", ok);
        op = 3'd0; src_a = 32'd4; src_b = 32'd4; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush_acc_ready", 64'(req_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;

        // Back-pressure in DONE: result held stable, then single-cycle handshake
        resp_ready = 1'b0;
        issue("stall_mult", 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, W+2);
        wait_valid("stall");
        check("stall_ready_done", 64'(req_ready), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("stall_held_valid", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        check("stall_hs_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("stall_after_valid", 64'(resp_valid), 64'd0);
        check("stall_after_ready", 64'(req_ready), 64'd1);
        drain();

        // Flush coinciding with handshake in DONE: held result discarded
        resp_ready = 1'b0;
        issue("flush_done", 3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 1'b0, W+2);
        wait_valid("flush_done");
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_valid", 64'(resp_valid), 64'd0);
        check("flush_done_ready", 64'(req_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        q.delete();

        // Reset mid-operation: abandoned, ready right after release
        wait_ready("rst_mid", ok);
        op = 3'd2; src_a = 32'd1000; src_b = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", 64'(req_ready), 64'd0);
        check("rst_mid_valid", 64'(resp_valid), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_release", 64'(req_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        run("post_rst",    3'd3, 32'd1000,     32'd3,        32'h0,        32'h0,        32'd1,        32'd333,      1'b0, W+2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want bench completion");
        $fatal(1, "watchdog");
    end

endmodule
